sysbus_arbiter: RTL

Shares the single system-bus master port between the cache controllers (icache, dcache, and any later requester) using the busreq/busgrant/busidle handshake those controllers already implement. Grants are round-robin, and ownership is held for a whole bus transaction, including multi-beat fills and dirty-line writebacks. The arbiter muxes the owner's request-side bus signals onto the shared bus. Response-side signals (bus_respcyc, bus_resp, bus_resptag, bus_reqack) are broadcast to all requesters outside this block; snoop invalidates (resptag 12'h800) need no arbitration.

---
 rtl/sysbus_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - round-robin owner arbiter for the shared system-bus master port
module sysbus_arbiter #(
  parameter int NREQ           = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int GRANT_TIMEOUT  = 8,
  parameter int OWNER_W        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 req_busreq,
  input  logic [NREQ-1:0]                 req_busidle,
  output logic [NREQ-1:0]                 req_busgrant,
  input  logic [NREQ-1:0]                 req_reqcyc,
  input  logic [NREQ-1:0]                 req_respack,
  input  logic [NREQ*BUS_DATA_WIDTH-1:0]  req_req,
  input  logic [NREQ*BUS_TAG_WIDTH-1:0]   req_reqtag,
  output logic                            bus_reqcyc,
  output logic                            bus_respack,
  output logic [BUS_DATA_WIDTH-1:0]       bus_req,
  output logic [BUS_TAG_WIDTH-1:0]        bus_reqtag,
  output logic [OWNER_W-1:0]              owner,
  output logic                            owner_valid,
  output logic                            grant_timeout
);

  localparam int WC_W = $clog2(GRANT_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

  state_t            state;
  logic [OWNER_W-1:0] ptr;
  logic [WC_W-1:0]    waitcnt;
  logic [OWNER_W-1:0] pick;
  logic               found;
  int                 idx;

  // First requesting index at or above ptr, wrapping; ptr itself when nobody asks.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req_busreq[idx]) begin
        pick  = OWNER_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      owner         <= '0;
      req_busgrant  <= '0;
      waitcnt       <= '0;
      grant_timeout <= 1'b0;
    end else begin
      grant_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            owner        <= pick;
            req_busgrant <= NREQ'(1) << pick;
            waitcnt      <= '0;
            state        <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!req_busidle[owner]) begin
            state <= S_BUSY;
          end else if (waitcnt == WC_W'(GRANT_TIMEOUT - 1)) begin
            req_busgrant  <= '0;
            grant_timeout <= 1'b1;
            state         <= S_RELEASE;
          end else begin
            waitcnt <= waitcnt + WC_W'(1);
          end
        end
        S_BUSY: begin
          // Held with no cap so a writeback plus refill stays one ownership.
          if (req_busidle[owner]) begin
            req_busgrant <= '0;
            state        <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (int'(owner) == NREQ - 1) ptr <= '0;
          else                         ptr <= owner + OWNER_W'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign owner_valid = (state == S_GRANT) || (state == S_BUSY);

  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    if (owner_valid) begin
      bus_reqcyc  = req_reqcyc[owner];
      bus_respack = req_respack[owner];
      bus_req     = req_req[owner*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      bus_reqtag  = req_reqtag[owner*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
    end
  end

endmodule
